seq_detect_scheduler: RTL and testbench

Shares one serial bit-pattern detector between `N_REQ` word-level requesters. Each accepted word is shifted MSB-first through the detector, and overlapping occurrences of a fixed pattern are counted. The count is returned with the requester's ID over a valid/ready response channel. The block sits between parallel producers and the bit-serial detection datapath, and supplies the arbitration and sequencing that the bare detector FSMs lack.

---
 rtl/seq_detect_scheduler.sv | 122 ++++++++++++
 tb/tb_seq_detect_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one MSB-first serial pattern detector among N_REQ word requesters.
// Optional macro SEQ_SCHED_LAST_POS_EN adds rsp_last_pos (bit index of the last completed match).
module seq_detect_scheduler #(
    parameter int                N_REQ   = 4,
    parameter int                WORD_W  = 16,
    parameter int                PAT_W   = 6,
    parameter logic [PAT_W-1:0]  PATTERN = 6'b110011,
    localparam int               ID_W    = $clog2(N_REQ),
    localparam int               CNT_W   = $clog2(WORD_W + 1),
    localparam int               POS_W   = $clog2(WORD_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*WORD_W-1:0]   req_word,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CNT_W-1:0]          rsp_count
`ifdef SEQ_SCHED_LAST_POS_EN
    ,
    output logic [POS_W-1:0]          rsp_last_pos
`endif
);

    generate
        if (PAT_W < 2 || PAT_W > WORD_W) begin : g_bad_pat_w
            $error("seq_detect_scheduler: PAT_W must satisfy 2 <= PAT_W <= WORD_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t              state, state_next;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_found;
    logic                accept;
    logic [WORD_W-1:0]   shreg;
    logic [PAT_W-1:0]    window;
    logic [PAT_W-1:0]    win_next;
    logic [POS_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    match_cnt;
    logic                last_bit;
    logic                match;

    // First valid requester at or after rr_ptr, wrapping mod N_REQ.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (grant_found) begin
                state_next = SCAN;
                accept     = 1'b1;
            end
            SCAN: if (last_bit) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gate on rst so nothing is granted while reset is held.
    assign req_ready = (accept && !rst) ? (N_REQ'(1) << grant_idx) : '0;
    assign rsp_valid = (state == RESP);
    assign rsp_count = match_cnt;

    assign win_next = {window[PAT_W-2:0], shreg[WORD_W-1]};
    assign last_bit = (bit_cnt == POS_W'(WORD_W - 1));
    // Window only holds this word's bits once PAT_W of them have been fed.
    assign match    = (win_next == PATTERN) && (bit_cnt >= POS_W'(PAT_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            rsp_id    <= '0;
            shreg     <= '0;
            window    <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
        end else if (accept) begin
            rr_ptr    <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            rsp_id    <= grant_idx;
            shreg     <= req_word[grant_idx*WORD_W +: WORD_W];
            window    <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
        end else if (state == SCAN) begin
            shreg   <= shreg << 1;
            window  <= win_next;
            bit_cnt <= bit_cnt + POS_W'(1);
            if (match) match_cnt <= match_cnt + CNT_W'(1);
        end
    end

`ifdef SEQ_SCHED_LAST_POS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          rsp_last_pos <= '0;
        else if (accept)                  rsp_last_pos <= '0;
        else if (state == SCAN && match)  rsp_last_pos <= bit_cnt;
    end
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed self-checking bench for seq_detect_scheduler at default parameters.
module tb_seq_detect_scheduler;

    localparam int N_REQ  = 4;
    localparam int WORD_W = 16;

    logic                     clk;
    logic                     rst;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*WORD_W-1:0]  req_word;
    logic [N_REQ-1:0]         req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [1:0]               rsp_id;
    logic [4:0]               rsp_count;
`ifdef SEQ_SCHED_LAST_POS_EN
    logic [3:0]               rsp_last_pos;
`endif

    int total = 0;
    int bad   = 0;

    seq_detect_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_word  (req_word),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count)
`ifdef SEQ_SCHED_LAST_POS_EN
        ,
        .rsp_last_pos (rsp_last_pos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_last(input string tag, input logic [31:0] exp);
`ifdef SEQ_SCHED_LAST_POS_EN
        chk(tag, 32'(rsp_last_pos), exp);
`else
        if (exp == 32'hFFFF_FFFF) $display("unused %s", tag);
`endif
    endtask

    // Called right after the accept edge T; returns just after edge T+16.
    task automatic wait_resp(input string tag);
        for (int i = 0; i < 15; i++) tick();
        chk({tag, "_early"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = '0;
        req_word  = '0;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_rsp_count", 32'(rsp_count), 32'd0);
        chk_last("rst_last_pos", 32'd0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("idle_no_grant", 32'(req_ready), 32'd0);

        // Basic count on requester 0, then backpressure.
        req_word[0*WORD_W +: WORD_W] = 16'hCCCC;
        req_valid = 4'b0001;
        #1;
        chk("basic_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("scan_ready_zero", 32'(req_ready), 32'd0);
        wait_resp("basic");
        chk("basic_id",    32'(rsp_id),    32'd0);
        chk("basic_count", 32'(rsp_count), 32'd3);
        chk_last("basic_last_pos", 32'd13);

        req_word[1*WORD_W +: WORD_W] = 16'h0033;
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid",     32'(rsp_valid), 32'd1);
            chk("bp_id",        32'(rsp_id),    32'd0);
            chk("bp_count",     32'(rsp_count), 32'd3);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk_last("bp_last_pos", 32'd13);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("bp_released",   32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b0010);

        // Tail match on requester 1.
        tick();
        req_valid = '0;
        wait_resp("tail");
        chk("tail_id",    32'(rsp_id),    32'd1);
        chk("tail_count", 32'(rsp_count), 32'd1);
        chk_last("tail_last_pos", 32'd15);
        rsp_ready = 1'b1;
        tick();

        // No match on requester 3; rsp_ready already high gives a one-cycle RESP.
        req_word[3*WORD_W +: WORD_W] = 16'hFFFF;
        req_valid = 4'b1000;
        #1;
        chk("nomatch_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        wait_resp("nomatch");
        chk("nomatch_id",    32'(rsp_id),    32'd3);
        chk("nomatch_count", 32'(rsp_count), 32'd0);
        chk_last("nomatch_last_pos", 32'd0);
        tick();
        chk("one_cycle_resp", 32'(rsp_valid), 32'd0);

        // Round-robin with all requesters valid and rsp_ready high.
        for (int i = 0; i < N_REQ; i++) req_word[i*WORD_W +: WORD_W] = 16'hCCCC;
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                tick();
                n = 1;
                while (req_ready == '0 && n < 40) begin
                    tick();
                    n++;
                end
                chk("rr_gap", 32'(n), 32'd18);
            end
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % N_REQ)));
        end
        req_valid = '0;
        tick();

        // Reset at bit 8 of requester 2's scan.
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        req_valid = 4'b0101;
        #1;
        chk("mid_rst_valid",     32'(rsp_valid), 32'd0);
        chk("mid_rst_id",        32'(rsp_id),    32'd0);
        chk("mid_rst_count",     32'(rsp_count), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk_last("mid_rst_last_pos", 32'd0);
        tick();
        tick();
        rst = 1'b0;
        req_word[0*WORD_W +: WORD_W] = 16'h0033;
        #1;
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        wait_resp("post_rst");
        chk("post_rst_id",    32'(rsp_id),    32'd0);
        chk("post_rst_count", 32'(rsp_count), 32'd1);
        chk_last("post_rst_last_pos", 32'd15);
        req_valid = 4'b0101;
        tick();
        chk("post_rst_done",  32'(rsp_valid), 32'd0);
        chk("post_rst_rr",    32'(req_ready), 32'b0100);
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
